// File: rtl/seg7_mux_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Segment patterns are active-high {g,f,e,d,c,b,a}. Polarity is applied only at
// the output registers of the top. Also holds the converter FSM state type and
// the helpers used to size the BCD scratch register and to decode a digit.
package seg7_mux_display_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [0:0] {StIdle, StShift} conv_state_e;

    // Number of decimal digits needed for 2^w - 1, i.e. ceil(log10(2^w)).
    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        n = 0;
        do begin
            n++;
            v = v / 64'd10;
        end while (v != 64'd0);
        return n;
    endfunction

    // BCD digit to active-high segments. Codes above 9 never reach the decoder.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start_i, bin_i    start a conversion of bin_i (accepted only when idle)
//   busy_o            conversion in progress
//   done_o            1-cycle pulse, bcd_o holds the result from this cycle on
//   bcd_o             packed BCD result, digit 0 in bits [3:0]
// A conversion takes DATA_W shift cycles after the start edge.
module bin_to_bcd_seq
    import seg7_mux_display_pkg::*;
#(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*BCD_DIGITS-1:0] bcd_o
);

    localparam int unsigned BcdW = 4 * BCD_DIGITS;
    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    conv_state_e       state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [BcdW-1:0]   bcd_adj;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;

    always_comb begin
        // Add 3 to every digit >= 5 so the following left shift carries correctly.
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    bcd_d   = '0;
                    cnt_d   = CntW'(DATA_W - 1);
                    state_d = StShift;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == StShift);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_mux_display.sv
// Multi-digit time-multiplexed 7-segment display driver.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load, bin_in capture bin_in when ready=1
//   ready        converter idle, a load is accepted
//   done         1-cycle pulse when the display registers take a new value
//   overflow     latched: last value did not fit in NUM_DIGITS digits
//   seg          segments {g,f,e,d,c,b,a}
//   an           one-hot digit enables, an[0] is the least significant digit
// The display is double-buffered: the old value keeps scanning while converting.
module seg7_mux_display
    import seg7_mux_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  ready,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned BcdDigits = dec_digits(DATA_W);
    localparam int unsigned PadDigits = (BcdDigits > NUM_DIGITS) ? BcdDigits : NUM_DIGITS;
    localparam int unsigned PadW      = 4 * PadDigits;
    localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned RefW      = $clog2(REFRESH_DIV);

    localparam logic [6:0]            SegIdle = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AnIdle  = {NUM_DIGITS{ACTIVE_LOW}};

    logic                   conv_busy;
    logic                   conv_done;
    logic [4*BcdDigits-1:0] conv_bcd;
    logic [PadW-1:0]        bcd_pad;

    logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
    logic                       ovf_q, ovf_d;
    logic                       done_q;
    logic [RefW-1:0]            ref_q, ref_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [6:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;

    logic                  ovf_new;
    logic                  seen_nz;
    logic [NUM_DIGITS-1:0] lit;
    logic [6:0]            pat;

    // ready stays low through the cycle in which the result is copied over.
    assign ready = !conv_busy && !conv_done;

    bin_to_bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BcdDigits)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (load && ready),
        .bin_i   (bin_in),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign bcd_pad = PadW'(conv_bcd);

    // Display buffer update and overflow detection.
    always_comb begin
        ovf_new = 1'b0;
        for (int i = 0; i < int'(PadDigits); i++) begin
            if (i >= int'(NUM_DIGITS) && bcd_pad[4*i +: 4] != 4'd0) begin
                ovf_new = 1'b1;
            end
        end

        digits_d = digits_q;
        ovf_d    = ovf_q;
        if (conv_done) begin
            ovf_d = ovf_new;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                digits_d[i] = bcd_pad[4*i +: 4];
            end
        end
    end

    // Leading-zero blanking: a digit is lit if it or any higher digit is nonzero.
    always_comb begin
        seen_nz = 1'b0;
        lit     = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (digits_q[i] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lit[i] = seen_nz || (i == 0) || !BLANK_LZ || ovf_q;
        end
    end

    // Refresh/scan counters and registered segment/anode outputs.
    always_comb begin
        ref_d = ref_q + RefW'(1);
        idx_d = idx_q;
        if (ref_q == RefW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end

        pat  = ovf_q ? SEG_DASH : seg_decode(digits_q[idx_q]);
        seg_d = SEG_OFF;
        an_d  = '0;
        if (lit[idx_q]) begin
            seg_d = pat;
            an_d  = NUM_DIGITS'(1) << idx_q;
        end
        if (ACTIVE_LOW) begin
            seg_d = ~seg_d;
            an_d  = ~an_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            ref_q    <= '0;
            idx_q    <= '0;
            seg_q    <= SegIdle;
            an_q     <= AnIdle;
        end else begin
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            done_q   <= conv_done;
            ref_q    <= ref_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign done     = done_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Scoreboard bench for seg7_mux_display (4 digits, 14-bit input, 4-cycle slots,
// active-low pins, leading-zero blanking).
module tb_seg7_mux_display;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 14;
    localparam int unsigned RD = 4;
    localparam int          LAT = DW + 1;

    // Active-high {g..a} patterns for decimal digits 0-9.
    localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] bin_in = '0;
    logic          ready, done, overflow;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    seg7_mux_display #(
        .NUM_DIGITS  (ND),
        .DATA_W      (DW),
        .REFRESH_DIV (RD),
        .ACTIVE_LOW  (1'b1),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .bin_in   (bin_in),
        .ready    (ready),
        .done     (done),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   acc;
        bit                   ovf;
        logic [ND-1:0][6:0]   pat;
        logic [ND-1:0]        lit;
    } exp_t;

    // Reference: decimal digits by division, dash on overflow, blank above MSD.
    function automatic exp_t model(input int unsigned v, input int acc);
        exp_t        e;
        int unsigned p;
        int unsigned dg;
        int          msd;
        e.acc = acc;
        e.ovf = (v > 9999);
        p     = 1;
        msd   = 0;
        for (int i = 0; i < int'(ND); i++) begin
            dg = (v / p) % 10;
            p  = p * 10;
            if (dg != 0) msd = i;
            e.pat[i] = e.ovf ? 7'h40 : SEGTAB[dg];
            e.lit[i] = e.ovf || (i <= msd);
        end
        return e;
    endfunction

    int   cyc = 0;
    int   k = 0;
    int   busy = 0;
    bit   started = 1'b0;
    exp_t q[$];

    int         n_checks = 0;
    int         n_errors = 0;
    int         rd = 0;
    int         slot;
    logic [6:0] es;
    logic [3:0] ea;
    exp_t       cur;
    exp_t       e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event at cycle %0d", name, cyc);
    endtask

    // Stimulus side: decides acceptance from its own busy model and pushes.
    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (reset) begin
            k    = 0;
            busy = 0;
        end else begin
            k++;
            if (load && busy == 0) begin
                q.push_back(model(int'(bin_in), cyc));
                busy = LAT;
            end else if (busy > 0) begin
                busy--;
            end
        end
    end

    // Monitor: checks scan every cycle, pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        if (started) begin
            if (k == 0) begin
                chk("rst_seg", 32'(seg), 32'h7F);
                chk("rst_an", 32'(an), 32'hF);
                chk("rst_ready", 32'(ready), 32'd1);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_ovf", 32'(overflow), 32'd0);
                cur = model(0, 0);
                rd  = q.size();
            end else begin
                chk("ready", 32'(ready), 32'(busy == 0));
                slot = ((k - 1) / int'(RD)) % int'(ND);
                ea   = cur.lit[slot] ? ~(4'b0001 << slot) : 4'hF;
                es   = cur.lit[slot] ? ~cur.pat[slot] : 7'h7F;
                chk("scan_an", 32'(an), 32'(ea));
                chk("scan_seg", 32'(seg), 32'(es));
                if (done) begin
                    if (rd >= q.size()) begin
                        fail_evt("unexpected_done");
                    end else begin
                        e = q[rd];
                        rd++;
                        chk("done_latency", 32'(cyc - e.acc), 32'(LAT));
                        chk("ovf_update", 32'(overflow), 32'(e.ovf));
                        cur = e;
                    end
                end else begin
                    chk("ovf_hold", 32'(overflow), 32'(cur.ovf));
                    if (rd < q.size() && (cyc - q[rd].acc) >= LAT) begin
                        fail_evt("done_missing");
                        rd++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int unsigned v);
        int guard;
        guard = 0;
        while (busy != 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        load   = 1'b1;
        bin_in = DW'(v);
        tick(1);
        load   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        do_load(1234);  tick(40);
        do_load(7);     tick(40);
        do_load(0);     tick(40);
        do_load(10000); tick(40);
        do_load(9999);  tick(40);

        // Second load lands while converting and must be dropped.
        do_load(42);
        tick(2);
        load   = 1'b1;
        bin_in = DW'(99);
        tick(1);
        load   = 1'b0;
        tick(40);

        // Reset in the middle of a conversion.
        do_load(5000);
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(30);
        do_load(12);    tick(40);

        for (int n = 0; n < 25; n++) begin
            do_load($urandom_range(0, 16383));
            tick($urandom_range(0, 25));
            if ($urandom_range(0, 1) == 1) begin
                load   = 1'b1;
                bin_in = DW'($urandom);
                tick(1);
                load   = 1'b0;
            end
        end
        tick(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
